// File: rtl/afe_cfg_arbiter.sv
// afe_cfg_arbiter: shares the per-AFE configuration port between NUM_REQ
// requesters. Round-robin grant, one transaction in flight, target AFE taken
// from address bits [10:8], and a timeout that releases a hung AFE with an
// error response to the requester.
module afe_cfg_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int NUM_AFE = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [NUM_REQ-1:0]     req_rwn_i,
  input  logic [NUM_REQ*11-1:0]  req_addr_i,
  input  logic [NUM_REQ*32-1:0]  req_wdata_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic                   req_err_o,
  output logic [31:0]            req_rdata_o,
  output logic [10:0]            cfg_addr_o,
  output logic [31:0]            cfg_wdata_o,
  output logic                   cfg_rwn_o,
  output logic [NUM_AFE-1:0]     cfg_valid_o,
  input  logic [NUM_AFE-1:0]     cfg_ready_i,
  input  logic [NUM_AFE*32-1:0]  cfg_rdata_i,
  output logic                   busy_o
);

  localparam int REQ_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t               r_state;
  logic [REQ_W-1:0]     r_rr_ptr;
  logic [REQ_W-1:0]     r_grant;
  logic [CNT_W-1:0]     r_cnt;
  logic [NUM_AFE-1:0]   r_cfg_valid;
  logic [10:0]          r_cfg_addr;
  logic [31:0]          r_cfg_wdata;
  logic                 r_cfg_rwn;
  logic [NUM_REQ-1:0]   r_req_ready;
  logic                 r_req_err;
  logic [31:0]          r_req_rdata;

  // Unpacked views of the flat request buses
  logic [10:0]          w_addr_arr  [NUM_REQ];
  logic [31:0]          w_wdata_arr [NUM_REQ];
  logic [NUM_REQ-1:0]   w_hi_mask;
  logic [NUM_REQ-1:0]   w_hi_req;
  logic [NUM_REQ-1:0]   w_pick;
  logic [NUM_REQ-1:0]   w_win_onehot;
  logic [NUM_REQ-1:0]   w_grant_onehot;
  logic                 w_any;
  logic [REQ_W-1:0]     w_win;
  logic [10:0]          w_win_addr;
  logic [31:0]          w_win_wdata;
  logic                 w_win_rwn;
  logic [NUM_AFE-1:0]   w_tgt_onehot;
  logic                 w_tgt_ok;
  logic [31:0]          w_rdata_masked [NUM_AFE];
  logic                 w_sel_ready;
  logic [31:0]          w_sel_rdata;
  logic [REQ_W-1:0]     w_rr_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign w_addr_arr[gi]     = req_addr_i[gi*11 +: 11];
      assign w_wdata_arr[gi]    = req_wdata_i[gi*32 +: 32];
      // Requesters at or above the pointer get first pick
      assign w_hi_mask[gi]      = (REQ_W'(gi) >= r_rr_ptr);
      assign w_win_onehot[gi]   = (w_win == REQ_W'(gi));
      assign w_grant_onehot[gi] = (r_grant == REQ_W'(gi));
    end
    for (gi = 0; gi < NUM_AFE; gi++) begin : g_afe
      assign w_tgt_onehot[gi]   = (w_win_addr[10:8] == 3'(gi));
      // Only the AFE currently being driven can contribute read data
      assign w_rdata_masked[gi] = cfg_rdata_i[gi*32 +: 32]
                                & {32{cfg_ready_i[gi] & r_cfg_valid[gi]}};
    end
  endgenerate

  assign w_hi_req = req_valid_i & w_hi_mask;
  assign w_pick   = (|w_hi_req) ? w_hi_req : req_valid_i;
  assign w_any    = |req_valid_i;

  // Lowest set bit of the rotated-priority vector wins
  always_comb begin
    w_win = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_pick[i]) w_win = REQ_W'(i);
    end
  end

  assign w_win_addr  = w_addr_arr[w_win];
  assign w_win_wdata = w_wdata_arr[w_win];
  assign w_win_rwn   = req_rwn_i[w_win];
  assign w_tgt_ok    = (w_win_addr[10:8] < 3'(NUM_AFE));

  // Ready/read data of the selected AFE (r_cfg_valid is one-hot in BUSY)
  assign w_sel_ready = |(cfg_ready_i & r_cfg_valid);
  always_comb begin
    w_sel_rdata = '0;
    for (int i = 0; i < NUM_AFE; i++) begin
      w_sel_rdata = w_sel_rdata | w_rdata_masked[i];
    end
  end

  assign w_rr_next = (r_grant == REQ_W'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;

  // Arbitration/transaction FSM with registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_cnt       <= '0;
      r_cfg_valid <= '0;
      r_cfg_addr  <= '0;
      r_cfg_wdata <= '0;
      r_cfg_rwn   <= 1'b1;
      r_req_ready <= '0;
      r_req_err   <= 1'b0;
      r_req_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_req_ready <= '0;
          r_req_err   <= 1'b0;
          r_req_rdata <= '0;
          if (w_any) begin
            r_grant     <= w_win;
            r_cfg_addr  <= w_win_addr;
            r_cfg_wdata <= w_win_wdata;
            r_cfg_rwn   <= w_win_rwn;
            r_cnt       <= '0;
            if (w_tgt_ok) begin
              r_state     <= BUSY;
              r_cfg_valid <= w_tgt_onehot;
            end else begin
              // No such AFE: answer with an error without touching the bus
              r_state     <= RESP;
              r_req_ready <= w_win_onehot;
              r_req_err   <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (w_sel_ready) begin
            // Ready beats a timeout expiring in the same cycle
            r_state     <= RESP;
            r_cfg_valid <= '0;
            r_req_ready <= w_grant_onehot;
            r_req_err   <= 1'b0;
            r_req_rdata <= r_cfg_rwn ? w_sel_rdata : 32'h0;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_state     <= RESP;
            r_cfg_valid <= '0;
            r_req_ready <= w_grant_onehot;
            r_req_err   <= 1'b1;
            r_req_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          r_req_ready <= '0;
          r_req_err   <= 1'b0;
          r_req_rdata <= '0;
          r_rr_ptr    <= w_rr_next;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready_o = r_req_ready;
  assign req_err_o   = r_req_err;
  assign req_rdata_o = r_req_rdata;
  assign cfg_addr_o  = r_cfg_addr;
  assign cfg_wdata_o = r_cfg_wdata;
  assign cfg_rwn_o   = r_cfg_rwn;
  assign cfg_valid_o = r_cfg_valid;
  assign busy_o      = (r_state != IDLE);

endmodule

// File: tb/tb_afe_cfg_arbiter.sv
// tb_afe_cfg_arbiter: directed tests for afe_cfg_arbiter (2 requesters,
// 4 AFEs, TIMEOUT=255). Simple AFE responders raise ready a programmable
// number of cycles after their cfg_valid rises.
module tb_afe_cfg_arbiter;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic [1:0]   req_valid_i;
  logic [1:0]   req_rwn_i;
  logic [21:0]  req_addr_i;
  logic [63:0]  req_wdata_i;
  logic [1:0]   req_ready_o;
  logic         req_err_o;
  logic [31:0]  req_rdata_o;
  logic [10:0]  cfg_addr_o;
  logic [31:0]  cfg_wdata_o;
  logic         cfg_rwn_o;
  logic [3:0]   cfg_valid_o;
  logic [3:0]   cfg_ready_i;
  logic [127:0] cfg_rdata_i;
  logic         busy_o;

  int total = 0;
  int bad   = 0;

  int          afe_delay [4] = '{default: 0};
  logic [31:0] afe_rdata [4] = '{default: 32'h0};
  int          wait_cnt  [4] = '{default: 0};

  afe_cfg_arbiter #(.NUM_REQ(2), .NUM_AFE(4), .TIMEOUT(255)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_rwn_i   (req_rwn_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_ready_o (req_ready_o),
    .req_err_o   (req_err_o),
    .req_rdata_o (req_rdata_o),
    .cfg_addr_o  (cfg_addr_o),
    .cfg_wdata_o (cfg_wdata_o),
    .cfg_rwn_o   (cfg_rwn_o),
    .cfg_valid_o (cfg_valid_o),
    .cfg_ready_i (cfg_ready_i),
    .cfg_rdata_i (cfg_rdata_i),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // AFE responders: count cycles with valid high, ready after afe_delay
  always @(posedge clk_i) begin
    for (int a = 0; a < 4; a++) begin
      if (cfg_valid_o[a]) wait_cnt[a] <= wait_cnt[a] + 1;
      else                wait_cnt[a] <= 0;
    end
  end

  always_comb begin
    cfg_ready_i = '0;
    cfg_rdata_i = '0;
    for (int a = 0; a < 4; a++) begin
      cfg_ready_i[a]        = cfg_valid_o[a] && (wait_cnt[a] == afe_delay[a]);
      cfg_rdata_i[a*32+:32] = afe_rdata[a];
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int r, input logic v, input logic rwn,
                         input logic [10:0] a, input logic [31:0] d);
    req_valid_i[r]       = v;
    req_rwn_i[r]         = rwn;
    req_addr_i[r*11+:11] = a;
    req_wdata_i[r*32+:32] = d;
  endtask

  task automatic test_reset();
    rst_ni      = 1'b0;
    req_valid_i = '0;
    req_rwn_i   = '0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    repeat (2) tick();
    total++;
    if ({cfg_valid_o, req_ready_o, req_err_o, req_rdata_o, cfg_addr_o, cfg_wdata_o, cfg_rwn_o, busy_o}
        !== {4'b0, 2'b0, 1'b0, 32'h0, 11'h0, 32'h0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reset_values got valid=%b rdy=%b err=%b rdata=%h addr=%h wdata=%h rwn=%b busy=%b exp all 0 rwn=1",
               cfg_valid_o, req_ready_o, req_err_o, req_rdata_o, cfg_addr_o, cfg_wdata_o, cfg_rwn_o, busy_o);
    end
    rst_ni = 1'b1;
    tick();
    $display("reset: released");
  endtask

  task automatic test_single_write();
    afe_delay[1] = 0;
    afe_rdata[1] = 32'hDEADBEEF;
    set_req(0, 1'b1, 1'b0, 11'h105, 32'hA5A5A5A5);
    tick();  // cycle 1
    total++;
    if ({cfg_valid_o, cfg_addr_o, cfg_wdata_o, cfg_rwn_o, busy_o, req_ready_o}
        !== {4'b0010, 11'h105, 32'hA5A5A5A5, 1'b0, 1'b1, 2'b00}) begin
      bad++;
      $display("FAIL wr_cycle1 got valid=%b addr=%h wdata=%h rwn=%b busy=%b rdy=%b exp 0010 105 a5a5a5a5 0 1 00",
               cfg_valid_o, cfg_addr_o, cfg_wdata_o, cfg_rwn_o, busy_o, req_ready_o);
    end
    tick();  // cycle 2
    total++;
    if ({req_ready_o, req_err_o, req_rdata_o, cfg_valid_o} !== {2'b01, 1'b0, 32'h0, 4'b0000}) begin
      bad++;
      $display("FAIL wr_resp got rdy=%b err=%b rdata=%h valid=%b exp 01 0 00000000 0000",
               req_ready_o, req_err_o, req_rdata_o, cfg_valid_o);
    end
    set_req(0, 1'b0, 1'b0, 11'h0, 32'h0);
    tick();  // back in IDLE
    total++;
    if ({req_ready_o, busy_o} !== 3'b000) begin
      bad++;
      $display("FAIL wr_after got rdy=%b busy=%b exp 00 0", req_ready_o, busy_o);
    end
    $display("single_write: req0 addr=105 done");
  endtask

  task automatic test_read_wait();
    int vcnt = 0;
    int got  = 0;
    afe_delay[3] = 5;
    afe_rdata[3] = 32'h12345678;
    set_req(1, 1'b1, 1'b1, 11'h310, 32'h0);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      tick();
      if (req_ready_o != 2'b00) begin
        got = cyc;
        break;
      end
      if (cfg_valid_o == 4'b1000) vcnt++;
    end
    total++;
    if (got != 7 || vcnt != 6) begin
      bad++;
      $display("FAIL rd_timing got resp_cycle=%0d valid_cycles=%0d exp 7 6", got, vcnt);
    end
    total++;
    if ({req_ready_o, req_err_o, req_rdata_o} !== {2'b10, 1'b0, 32'h12345678}) begin
      bad++;
      $display("FAIL rd_resp got rdy=%b err=%b rdata=%h exp 10 0 12345678", req_ready_o, req_err_o, req_rdata_o);
    end
    set_req(1, 1'b0, 1'b0, 11'h0, 32'h0);
    tick();
    total++;
    if ({req_ready_o, req_err_o, req_rdata_o} !== {2'b00, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL rd_clear got rdy=%b err=%b rdata=%h exp 00 0 0", req_ready_o, req_err_o, req_rdata_o);
    end
    $display("read_wait: req1 addr=310 rdata=%h", 32'h12345678);
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp;
    int multi = 0;
    afe_delay[0] = 0;
    afe_delay[1] = 0;
    set_req(0, 1'b1, 1'b0, 11'h000, 32'h11111111);
    set_req(1, 1'b1, 1'b1, 11'h100, 32'h0);
    for (int n = 0; n < 6; n++) begin
      int c = 0;
      exp = (n % 2 == 0) ? 2'b01 : 2'b10;
      for (int k = 0; k < 8; k++) begin
        tick();
        c++;
        if ($countones(cfg_valid_o) > 1) multi++;
        if (req_ready_o != 2'b00) break;
      end
      total++;
      if (req_ready_o !== exp || c != ((n == 0) ? 2 : 3)) begin
        bad++;
        $display("FAIL b2b_grant%0d got rdy=%b cycles=%0d exp %b %0d", n, req_ready_o, c, exp, (n == 0) ? 2 : 3);
      end
      $display("back_to_back: txn %0d granted rdy=%b", n, req_ready_o);
    end
    set_req(0, 1'b0, 1'b0, 11'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 11'h0, 32'h0);
    tick();
    total++;
    if (multi != 0) begin
      bad++;
      $display("FAIL b2b_onehot got multi_valid_cycles=%0d exp 0", multi);
    end
  endtask

  task automatic test_timeout();
    int vcnt = 0;
    int got  = 0;
    afe_delay[2] = 100000;
    afe_rdata[2] = 32'hFFFF0000;
    set_req(0, 1'b1, 1'b1, 11'h2AA, 32'h0);
    for (int cyc = 1; cyc <= 400; cyc++) begin
      tick();
      if (req_ready_o != 2'b00) begin
        got = cyc;
        break;
      end
      if (cfg_valid_o == 4'b0100) vcnt++;
    end
    total++;
    if (vcnt != 255 || got != 256) begin
      bad++;
      $display("FAIL to_timing got valid_cycles=%0d resp_cycle=%0d exp 255 256", vcnt, got);
    end
    total++;
    if ({req_ready_o, req_err_o, req_rdata_o} !== {2'b01, 1'b1, 32'h0}) begin
      bad++;
      $display("FAIL to_resp got rdy=%b err=%b rdata=%h exp 01 1 00000000", req_ready_o, req_err_o, req_rdata_o);
    end
    $display("timeout: req0 addr=2aa err=%b", req_err_o);
    set_req(0, 1'b0, 1'b0, 11'h0, 32'h0);
    tick();
    // Following request to the same AFE completes normally
    afe_delay[2] = 2;
    afe_rdata[2] = 32'hCAFEF00D;
    set_req(1, 1'b1, 1'b1, 11'h2F0, 32'h0);
    got = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      tick();
      if (req_ready_o != 2'b00) begin
        got = cyc;
        break;
      end
    end
    total++;
    if (got != 4 || {req_ready_o, req_err_o, req_rdata_o} !== {2'b10, 1'b0, 32'hCAFEF00D}) begin
      bad++;
      $display("FAIL to_next got cycle=%0d rdy=%b err=%b rdata=%h exp 4 10 0 cafef00d",
               got, req_ready_o, req_err_o, req_rdata_o);
    end
    $display("timeout: follow-up req1 rdata=%h", req_rdata_o);
    set_req(1, 1'b0, 1'b0, 11'h0, 32'h0);
    tick();
  endtask

  task automatic test_invalid_target();
    set_req(1, 1'b1, 1'b0, 11'h600, 32'h0BAD0BAD);
    tick();  // cycle 1
    total++;
    if ({req_ready_o, req_err_o, req_rdata_o, cfg_valid_o, busy_o} !== {2'b10, 1'b1, 32'h0, 4'b0000, 1'b1}) begin
      bad++;
      $display("FAIL inv_resp got rdy=%b err=%b rdata=%h valid=%b busy=%b exp 10 1 0 0000 1",
               req_ready_o, req_err_o, req_rdata_o, cfg_valid_o, busy_o);
    end
    set_req(1, 1'b0, 1'b0, 11'h0, 32'h0);
    tick();  // cycle 2
    total++;
    if ({req_ready_o, req_err_o, cfg_valid_o, busy_o} !== {2'b00, 1'b0, 4'b0000, 1'b0}) begin
      bad++;
      $display("FAIL inv_after got rdy=%b err=%b valid=%b busy=%b exp 00 0 0000 0",
               req_ready_o, req_err_o, cfg_valid_o, busy_o);
    end
    $display("invalid_target: req1 addr=600 err=1");
  endtask

  task automatic test_reset_mid();
    int got = 0;
    // Quick req0 transaction moves the pointer to requester 1
    afe_delay[1] = 0;
    set_req(0, 1'b1, 1'b0, 11'h100, 32'h55);
    tick();
    tick();
    total++;
    if (req_ready_o !== 2'b01) begin
      bad++;
      $display("FAIL rm_pre got rdy=%b exp 01", req_ready_o);
    end
    set_req(0, 1'b0, 1'b0, 11'h0, 32'h0);
    tick();
    afe_delay[0] = 100000;
    set_req(1, 1'b1, 1'b1, 11'h0FF, 32'h0);
    repeat (3) tick();
    total++;
    if ({cfg_valid_o, busy_o} !== {4'b0001, 1'b1}) begin
      bad++;
      $display("FAIL rm_busy got valid=%b busy=%b exp 0001 1", cfg_valid_o, busy_o);
    end
    rst_ni = 1'b0;
    #1;
    total++;
    if ({cfg_valid_o, busy_o, req_ready_o} !== {4'b0000, 1'b0, 2'b00}) begin
      bad++;
      $display("FAIL rm_async got valid=%b busy=%b rdy=%b exp 0000 0 00", cfg_valid_o, busy_o, req_ready_o);
    end
    tick();
    total++;
    if ({cfg_valid_o, busy_o, req_ready_o} !== {4'b0000, 1'b0, 2'b00}) begin
      bad++;
      $display("FAIL rm_hold got valid=%b busy=%b rdy=%b exp 0000 0 00", cfg_valid_o, busy_o, req_ready_o);
    end
    afe_delay[0] = 0;
    afe_rdata[1] = 32'h5A5A0001;
    set_req(0, 1'b1, 1'b1, 11'h1AB, 32'h0);
    rst_ni = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      tick();
      if (req_ready_o != 2'b00) begin
        got = cyc;
        break;
      end
    end
    total++;
    if (got != 2 || {req_ready_o, req_rdata_o} !== {2'b01, 32'h5A5A0001}) begin
      bad++;
      $display("FAIL rm_first got cycle=%0d rdy=%b rdata=%h exp 2 01 5a5a0001", got, req_ready_o, req_rdata_o);
    end
    $display("reset_mid: first grant after reset rdy=%b", req_ready_o);
    set_req(0, 1'b0, 1'b0, 11'h0, 32'h0);
    got = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      tick();
      if (req_ready_o != 2'b00) begin
        got = cyc;
        break;
      end
    end
    total++;
    if (got != 3 || req_ready_o !== 2'b10 || req_err_o !== 1'b0) begin
      bad++;
      $display("FAIL rm_second got cycle=%0d rdy=%b err=%b exp 3 10 0", got, req_ready_o, req_err_o);
    end
    $display("reset_mid: second grant rdy=%b", req_ready_o);
    set_req(1, 1'b0, 1'b0, 11'h0, 32'h0);
    tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_wait();
    test_back_to_back();
    test_timeout();
    test_invalid_target();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got time=%0t exp completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/afe_cfg_arbiter.md
Name: afe_cfg_arbiter

Overview:
- Shares the per-AFE configuration port (cfg_addr/wdata/rwn/valid/ready/rdata) between NUM_REQ requesters, e.g. the APB decoder and an autonomous AFE boot sequencer.
- Round-robin arbitration, one outstanding transaction at a time.
- Target AFE is decoded from the request address.
- A hung AFE is released by a timeout and signalled to the requester as an error.

Parameters:
- NUM_REQ, 2, number of requesters (>=1)
- NUM_AFE, 4, number of AFE cfg targets (1..7)
- TIMEOUT, 255, max cycles waiting for cfg_ready_i before error (>=1)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  NUM_REQ  request valid per requester
- req_rwn_i  in  NUM_REQ  1=read, 0=write
- req_addr_i  in  NUM_REQ*11  word address; [10:8]=AFE index, [7:0]=register
- req_wdata_i  in  NUM_REQ*32  write data
- req_ready_o  out  NUM_REQ  one-cycle completion pulse
- req_err_o  out  1  error flag, valid with req_ready_o
- req_rdata_o  out  32  read data, valid with req_ready_o
- cfg_addr_o  out  11  to AFEs
- cfg_wdata_o  out  32  to AFEs
- cfg_rwn_o  out  1  to AFEs
- cfg_valid_o  out  NUM_AFE  one-hot valid to the selected AFE
- cfg_ready_i  in  NUM_AFE  per-AFE ready
- cfg_rdata_i  in  NUM_AFE*32  per-AFE read data
- busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset values:
  - state=IDLE, rr_ptr=0
  - all outputs 0: cfg_valid_o, req_ready_o, req_err_o, req_rdata_o, cfg_addr_o, cfg_wdata_o, busy_o
  - cfg_rwn_o=1
- States:
  - IDLE -> BUSY when any req_valid_i is set and the target index is < NUM_AFE.
  - IDLE -> RESP directly with err=1 when the winner targets an index >= NUM_AFE.
  - BUSY -> RESP when cfg_ready_i[target] is high or the timeout expires.
  - RESP -> IDLE unconditionally.
- Arbitration (IDLE only):
  - Winner = first set req_valid_i scanning from rr_ptr upward, with wrap-around.
  - The winner's rwn/addr/wdata are registered on the IDLE->BUSY edge.
  - cfg_* outputs come from these registers, so they are stable for the whole transaction.
  - Requester inputs are ignored after grant.
- BUSY:
  - cfg_valid_o[target]=1; all other bits 0.
  - cfg_addr_o, cfg_wdata_o and cfg_rwn_o hold the registered request.
  - Completion: on the first cycle with cfg_ready_i[target]=1, capture cfg_rdata_i[target] into the response register (reads only; writes capture 0), err=0.
  - Timeout: counter is cleared on entering BUSY and increments each BUSY cycle without ready. When it reaches TIMEOUT-1 without ready, go to RESP with err=1, rdata=0.
  - Ready arriving in the same cycle as the last count wins: err=0.
- RESP:
  - cfg_valid_o=0.
  - req_ready_o[granted]=1 for exactly one cycle, with req_rdata_o/req_err_o valid.
  - rr_ptr <= (granted+1) mod NUM_REQ.
  - req_rdata_o/req_err_o return to 0 when req_ready_o is low.
- Latency:
  - Request sampled in IDLE (cycle 0) -> cfg_valid_o asserted at cycle 1.
  - cfg_ready_i seen at cycle k -> req_ready_o at cycle k+1.
  - Zero-wait AFE: req_ready_o at cycle 2.
  - Invalid target: req_ready_o at cycle 1.
- Requester protocol:
  - Hold req_valid_i and payload until the req_ready_o pulse; drop or issue the next request after it.
  - Dropping req_valid_i before completion does not abort a granted transaction; the response pulse is still produced.
- Fairness: a requester that keeps req_valid_i high cannot be granted twice in a row while another requester is pending.
- Reset mid-transaction: immediate return to IDLE, cfg_valid_o=0, no response pulse, rr_ptr=0.
- Only one cfg_valid_o bit is ever high; req_ready_o is at most one-hot.

Test Plan:
- Single write, requester 0, addr=0x105, wdata=0xA5A5A5A5, AFE1 ready immediately -> cfg_valid_o=4'b0010 at cycle 1 with addr 0x105 and the data; req_ready_o[0] pulses at cycle 2; err=0.
- Read, requester 1, addr=0x310, AFE3 ready after 5 cycles with rdata 0x12345678 -> cfg_valid_o=4'b1000 held 6 cycles; req_rdata_o=0x12345678 with the req_ready_o[1] pulse; err=0.
- Both requesters held valid continuously for 6 transactions, zero-wait AFEs -> grants alternate 0,1,0,1,0,1; no back-to-back repeat.
- AFE2 never ready, TIMEOUT=255 -> cfg_valid_o[2] high exactly 255 cycles; then req_ready_o pulse with err=1, rdata=0; next request is served normally.
- Address 0x600 (index 6 >= NUM_AFE) -> cfg_valid_o never asserts; req_ready_o at cycle 1 with err=1.
- rst_ni asserted while BUSY on AFE0 -> cfg_valid_o=0 and busy_o=0 immediately; no req_ready_o; after release, requester 0 wins when both request.
